// File: rtl/keypad_pkg.sv
// Package: keypad_pkg
// Shared definitions for the 4x4 Pmod KYPD scanner:
//   scan_state_t   debounce FSM states (IDLE, PRESS_CHK, HELD, REL_CHK)
//   KEYMAP         16-entry keycap table indexed by {row, col}
//   KEY_ENTER      keycap that commits a time entry (A)
//   KEY_CLEAR      keycap that clears the entry buffer (C)
//   keymap_lookup  row/column index -> keycap hex value
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_REL_CHK
  } scan_state_t;

  // Entry {r,c} sits at index r*4+c; listed from index 15 down to 0.
  // Rows: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  function automatic logic [3:0] keymap_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Module: keypad_col_driver
// Drives the keypad columns one at a time (active-low) and tells the
// scanner when to sample the rows.
//   clk, reset  clock, asynchronous active-high reset
//   col         column drive, exactly one bit low; 1110 after reset
//   col_idx     index of the column currently driven low
//   sample      high on the last dwell cycle of each column
module keypad_col_driver #(
  parameter int unsigned DWELL = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample
);
  import keypad_pkg::*;

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] dwell_cnt;

  assign sample = (dwell_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col       <= 4'b1110;
    end else if (sample) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
      col       <= {col[2:0], col[3]};
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_keypad_scanner.sv
// Module: pmod_keypad_scanner
// Scans a 4x4 Pmod KYPD, debounces across full scans and delivers one key
// code per press on a valid/ready handshake.
//   clk, reset     clock, asynchronous active-high reset
//   row            keypad rows, active-low (external pull-ups)
//   col            keypad columns, active-low, one low at a time
//   key_code       confirmed keycap hex value
//   key_valid      key_code holds an unconsumed key
//   key_ready      consumer accepts; transfer on key_valid && key_ready
//   key_held       a confirmed key is still physically pressed
//   overflow       1-cycle pulse: confirmed key dropped, previous still pending
//   entry_minutes  assembled minutes 0..59 (KEYPAD_TIME_ENTRY_EN)
//   entry_seconds  assembled seconds 0..59 (KEYPAD_TIME_ENTRY_EN)
//   entry_valid    1-cycle pulse on a successful commit (KEYPAD_TIME_ENTRY_EN)
// Build option: define KEYPAD_TIME_ENTRY_EN to include the MmSs time-entry
// accumulator; otherwise the entry outputs are tied to zero.
module pmod_keypad_scanner #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  output logic [5:0] entry_minutes,
  output logic [5:0] entry_seconds,
  output logic       entry_valid
);
  import keypad_pkg::*;

  localparam int unsigned DWELL = CLK_FREQ / SCAN_HZ;
  localparam logic [3:0]  DEB   = 4'(DEBOUNCE_SCANS);

  logic [3:0]  row_meta, row_sync;
  logic [1:0]  col_idx;
  logic        sample;

  logic [1:0]  col_hits, col_row;
  logic [3:0]  col_key;
  logic [2:0]  hit_sum;
  logic [1:0]  scan_hits;
  logic [3:0]  scan_key;
  logic [1:0]  acc_hits;
  logic [3:0]  acc_key;
  logic        scan_done, scan_one;

  scan_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cand, cand_nxt, cnt_inc;
  logic        confirm, release_done;

  keypad_col_driver #(.DWELL(DWELL)) u_col_driver (
    .clk     (clk),
    .reset   (reset),
    .col     (col),
    .col_idx (col_idx),
    .sample  (sample)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Hit counts saturate at 2: anything beyond one pressed switch per scan
  // is MULTI and handled like NONE.
  always_comb begin
    col_hits = 2'd0;
    col_row  = 2'd0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
        col_row  = 2'(r);
      end
    end
    col_key = keymap_lookup(col_row, col_idx);
    hit_sum = {1'b0, acc_hits} + {1'b0, col_hits};
    if (col_idx == 2'd0) begin
      scan_hits = col_hits;
      scan_key  = col_key;
    end else begin
      scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      scan_key  = (col_hits == 2'd1) ? col_key : acc_key;
    end
  end

  assign scan_done = sample && (col_idx == 2'd3);
  assign scan_one  = (scan_hits == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hits <= '0;
      acc_key  <= '0;
    end else if (sample) begin
      acc_hits <= scan_hits;
      acc_key  <= scan_key;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cand_nxt     = cand;
    confirm      = 1'b0;
    release_done = 1'b0;
    if (scan_done) begin
      unique case (state)
        ST_IDLE: begin
          if (scan_one) begin
            cand_nxt = scan_key;
            if (DEB == 4'd1) begin
              confirm   = 1'b1;
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (scan_one && scan_key == cand) begin
            if (cnt_inc == DEB) begin
              confirm   = 1'b1;
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (!scan_one) begin
            if (DEB == 4'd1) begin
              release_done = 1'b1;
              state_nxt    = ST_IDLE;
              cnt_nxt      = '0;
            end else begin
              state_nxt = ST_REL_CHK;
              cnt_nxt   = 4'd1;
            end
          end
        end
        ST_REL_CHK: begin
          if (scan_one) begin
            state_nxt = ST_HELD;
            cnt_nxt   = '0;
          end else if (cnt_inc == DEB) begin
            release_done = 1'b1;
            state_nxt    = ST_IDLE;
            cnt_nxt      = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A confirm in the same cycle as a transfer reuses the freed slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= confirm && key_valid && !key_ready;
      if (confirm && (!key_valid || key_ready)) begin
        key_code  <= scan_key;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (confirm) begin
        key_held <= 1'b1;
      end else if (release_done) begin
        key_held <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_TIME_ENTRY_EN
  logic [15:0] entry_buf;
  logic [6:0]  buf_mins, buf_secs;

  assign buf_mins = 7'(entry_buf[15:12]) * 7'd10 + 7'(entry_buf[11:8]);
  assign buf_secs = 7'(entry_buf[7:4])   * 7'd10 + 7'(entry_buf[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_buf     <= '0;
      entry_minutes <= '0;
      entry_seconds <= '0;
      entry_valid   <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      if (confirm) begin
        if (scan_key <= 4'd9) begin
          entry_buf <= {entry_buf[11:0], scan_key};
        end else if (scan_key == KEY_CLEAR) begin
          entry_buf <= '0;
        end else if (scan_key == KEY_ENTER) begin
          if (buf_mins <= 7'd59 && buf_secs <= 7'd59) begin
            entry_minutes <= buf_mins[5:0];
            entry_seconds <= buf_secs[5:0];
            entry_valid   <= 1'b1;
          end else begin
            entry_buf <= '0;
          end
        end
      end
    end
  end
`else
  assign entry_minutes = '0;
  assign entry_seconds = '0;
  assign entry_valid   = 1'b0;
`endif

endmodule
